adc_capture_stream: RTL and testbench



---
 rtl/adc_capture_pkg.sv | 21 ++
 rtl/capture_ram.sv | 24 ++
 rtl/adc_capture_stream.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_adc_capture_stream.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the triggered ADC capture engine.
package adc_capture_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StWait,
    StPost,
    StSend
  } state_e;

  localparam logic [7:0] HdrByteDefault = 8'hA5;
  localparam logic [7:0] FlagForced     = 8'h01;
  localparam logic [7:0] FlagReal       = 8'h00;

  // Bytes needed on the link to carry one sample of the given width.
  function automatic int unsigned bytes_per_sample(input int unsigned data_w);
    return (data_w + 7) / 8;
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port capture buffer: one write port, one registered read port.
module capture_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Synchronous write and registered read; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_capture_stream.sv
// Triggered ADC capture with decimation, circular pre-trigger buffer and a framed
// byte stream towards the UART transmitter.
// Optional build macro ADC_CAPTURE_AUTOTRIG_EN adds a WAIT timeout that forces a
// trigger, an auto_trig output and a flag byte after the header.
module adc_capture_stream
  import adc_capture_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned PRETRIG  = 32,
  parameter int unsigned DECIM_W  = 16,
  parameter logic [7:0]  HDR_BYTE = HdrByteDefault
`ifdef ADC_CAPTURE_AUTOTRIG_EN
  ,
  parameter int unsigned AUTO_SAMPLES = 4096
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  adc_data,
  input  logic               arm,
  input  logic [DECIM_W-1:0] decim,
  input  logic [DATA_W-1:0]  trig_level,
  input  logic               trig_falling,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               triggered
`ifdef ADC_CAPTURE_AUTOTRIG_EN
  ,
  output logic               auto_trig
`endif
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned BPS    = bytes_per_sample(DATA_W);
  localparam int unsigned POST_N = DEPTH - PRETRIG - 1;
`ifdef ADC_CAPTURE_AUTOTRIG_EN
  localparam int unsigned NHDR   = 2;
  localparam logic [31:0] AutoLast = 32'(AUTO_SAMPLES - 1);
`else
  localparam int unsigned NHDR   = 1;
`endif
  localparam logic [AW-1:0] PreLast  = AW'(PRETRIG - 1);
  localparam logic [AW-1:0] PostLast = AW'(POST_N - 1);
  localparam logic [AW:0]   DepthC   = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   DepthM1  = (AW + 1)'(DEPTH - 1);
  localparam logic [1:0]    NhdrC    = 2'(NHDR);

  // Capture side
  state_e             state_q, state_d;
  logic [DECIM_W-1:0] decim_q, decim_d, dcnt_q, dcnt_d;
  logic [DATA_W-1:0]  lvl_q, lvl_d, prev_q, prev_d;
  logic               fall_q, fall_d;
  logic [AW-1:0]      wptr_q, wptr_d, cnt_q, cnt_d, trig_addr_q, trig_addr_d;
  logic               triggered_q, triggered_d;
  logic               sample_en, trig_cond, auto_hit, send_start, frame_done;
`ifdef ADC_CAPTURE_AUTOTRIG_EN
  logic [31:0]        auto_cnt_q, auto_cnt_d;
  logic               auto_trig_q, auto_trig_d;
`endif

  // Send side
  logic [AW-1:0]      rd_addr_q, rd_addr_d;
  logic [AW:0]        rd_issued_q, rd_issued_d, ld_cnt_q, ld_cnt_d;
  logic               rvld_q, rvld_d, last_q, last_d, bidx_q, bidx_d;
  logic [1:0]         hdr_idx_q, hdr_idx_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               re, consume;
  logic [DATA_W-1:0]  rd_data;
  logic [15:0]        samp_pad;

  assign trig_cond = fall_q ? ((prev_q >= lvl_q) && (adc_data < lvl_q))
                            : ((prev_q < lvl_q) && (adc_data >= lvl_q));
  assign frame_done = (state_q == StSend) && tx_valid_q && tx_ready && last_q;
  assign samp_pad   = 16'(rd_data);

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (sample_en),
    .waddr (wptr_q),
    .wdata (adc_data),
    .re    (re),
    .raddr (rd_addr_q),
    .rdata (rd_data)
  );

  // Capture FSM, decimator and trigger detection.
  always_comb begin
    state_d     = state_q;
    decim_d     = decim_q;
    dcnt_d      = dcnt_q;
    lvl_d       = lvl_q;
    fall_d      = fall_q;
    prev_d      = prev_q;
    wptr_d      = wptr_q;
    cnt_d       = cnt_q;
    trig_addr_d = trig_addr_q;
    triggered_d = triggered_q;
    sample_en   = 1'b0;
    send_start  = 1'b0;
`ifdef ADC_CAPTURE_AUTOTRIG_EN
    auto_cnt_d  = auto_cnt_q;
    auto_trig_d = auto_trig_q;
    auto_hit    = (state_q == StWait) && (auto_cnt_q == AutoLast);
`else
    auto_hit    = 1'b0;
`endif

    if (state_q inside {StPre, StWait, StPost}) begin
      if (dcnt_q == decim_q) begin
        sample_en = 1'b1;
        dcnt_d    = '0;
      end else begin
        dcnt_d = dcnt_q + DECIM_W'(1);
      end
    end
    if (sample_en) begin
      wptr_d = wptr_q + AW'(1);
      prev_d = adc_data;
    end

    unique case (state_q)
      StIdle: begin
        if (arm) begin
          decim_d = decim;
          lvl_d   = trig_level;
          fall_d  = trig_falling;
          dcnt_d  = '0;
          cnt_d   = '0;
          prev_d  = '0;
          state_d = (PRETRIG == 0) ? StWait : StPre;
`ifdef ADC_CAPTURE_AUTOTRIG_EN
          auto_cnt_d  = '0;
          auto_trig_d = 1'b0;
`endif
        end
      end
      StPre: begin
        if (sample_en) begin
          if (cnt_q == PreLast) begin
            cnt_d   = '0;
            state_d = StWait;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      StWait: begin
        if (sample_en) begin
`ifdef ADC_CAPTURE_AUTOTRIG_EN
          auto_cnt_d = auto_cnt_q + 32'd1;
`endif
          if (trig_cond || auto_hit) begin
            trig_addr_d = wptr_q;
            triggered_d = 1'b1;
            cnt_d       = '0;
`ifdef ADC_CAPTURE_AUTOTRIG_EN
            auto_trig_d = !trig_cond;
`endif
            if (POST_N == 0) begin
              state_d    = StSend;
              send_start = 1'b1;
            end else begin
              state_d = StPost;
            end
          end
        end
      end
      StPost: begin
        if (sample_en) begin
          if (cnt_q == PostLast) begin
            state_d    = StSend;
            send_start = 1'b1;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      StSend: begin
        if (frame_done) begin
          state_d     = StIdle;
          triggered_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Frame serializer: header, optional flag, then samples MSB first with RAM read-ahead.
  always_comb begin
    rd_addr_d   = rd_addr_q;
    rd_issued_d = rd_issued_q;
    ld_cnt_d    = ld_cnt_q;
    rvld_d      = rvld_q;
    last_d      = last_q;
    bidx_d      = bidx_q;
    hdr_idx_d   = hdr_idx_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    re          = 1'b0;
    consume     = 1'b0;

    if (send_start) begin
      // After the final POST write the write pointer sits on the oldest kept
      // sample, which is exactly trig_addr - PRETRIG.
      rd_addr_d   = wptr_d;
      rd_issued_d = '0;
      ld_cnt_d    = '0;
      rvld_d      = 1'b0;
      last_d      = 1'b0;
      bidx_d      = 1'b0;
      hdr_idx_d   = '0;
    end else if (state_q == StSend) begin
      if (frame_done) begin
        tx_valid_d = 1'b0;
      end else if (!tx_valid_q || tx_ready) begin
        if (hdr_idx_q < NhdrC) begin
          tx_valid_d = 1'b1;
          hdr_idx_d  = hdr_idx_q + 2'd1;
`ifdef ADC_CAPTURE_AUTOTRIG_EN
          tx_data_d  = (hdr_idx_q == 2'd0) ? HDR_BYTE : (auto_trig_q ? FlagForced : FlagReal);
`else
          tx_data_d  = HDR_BYTE;
`endif
        end else if (rvld_q) begin
          tx_valid_d = 1'b1;
          if ((BPS == 2) && !bidx_q) begin
            tx_data_d = samp_pad[15:8];
            bidx_d    = 1'b1;
          end else begin
            tx_data_d = samp_pad[7:0];
            bidx_d    = 1'b0;
            consume   = 1'b1;
            ld_cnt_d  = ld_cnt_q + (AW + 1)'(1);
            last_d    = (ld_cnt_q == DepthM1);
          end
        end else begin
          tx_valid_d = 1'b0;
        end
      end
      // Refill the read register as soon as its sample is (being) consumed.
      re = (rd_issued_q != DepthC) && (!rvld_q || consume);
      if (re) begin
        rd_addr_d   = rd_addr_q + AW'(1);
        rd_issued_d = rd_issued_q + (AW + 1)'(1);
        rvld_d      = 1'b1;
      end else if (consume) begin
        rvld_d = 1'b0;
      end
    end
  end

  // Capture state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      decim_q     <= '0;
      dcnt_q      <= '0;
      lvl_q       <= '0;
      fall_q      <= 1'b0;
      prev_q      <= '0;
      wptr_q      <= '0;
      cnt_q       <= '0;
      trig_addr_q <= '0;
      triggered_q <= 1'b0;
`ifdef ADC_CAPTURE_AUTOTRIG_EN
      auto_cnt_q  <= '0;
      auto_trig_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      decim_q     <= decim_d;
      dcnt_q      <= dcnt_d;
      lvl_q       <= lvl_d;
      fall_q      <= fall_d;
      prev_q      <= prev_d;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
      trig_addr_q <= trig_addr_d;
      triggered_q <= triggered_d;
`ifdef ADC_CAPTURE_AUTOTRIG_EN
      auto_cnt_q  <= auto_cnt_d;
      auto_trig_q <= auto_trig_d;
`endif
    end
  end

  // Send state registers; reset drops tx_valid immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q   <= '0;
      rd_issued_q <= '0;
      ld_cnt_q    <= '0;
      rvld_q      <= 1'b0;
      last_q      <= 1'b0;
      bidx_q      <= 1'b0;
      hdr_idx_q   <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
    end else begin
      rd_addr_q   <= rd_addr_d;
      rd_issued_q <= rd_issued_d;
      ld_cnt_q    <= ld_cnt_d;
      rvld_q      <= rvld_d;
      last_q      <= last_d;
      bidx_q      <= bidx_d;
      hdr_idx_q   <= hdr_idx_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = (state_q != StIdle);
  assign triggered = triggered_q;
`ifdef ADC_CAPTURE_AUTOTRIG_EN
  assign auto_trig = auto_trig_q;
`endif

endmodule

// File: tb/tb_adc_capture_stream.sv
// Randomized scoreboard bench for adc_capture_stream (12-bit samples, 16-deep buffer).
module tb_adc_capture_stream;

  localparam int unsigned DW      = 12;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned PRETRIG = 4;
  localparam int unsigned DECIM_W = 8;
  localparam int unsigned POST_N  = DEPTH - PRETRIG - 1;
`ifdef ADC_CAPTURE_AUTOTRIG_EN
  localparam int unsigned AUTO_N  = 8;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [DW-1:0]      adc_data = '0;
  logic               arm = 1'b0;
  logic [DECIM_W-1:0] decim = '0;
  logic [DW-1:0]      trig_level = '0;
  logic               trig_falling = 1'b0;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready = 1'b0;
  logic               busy;
  logic               triggered;
`ifdef ADC_CAPTURE_AUTOTRIG_EN
  logic               auto_trig;
`endif

  int         errors = 0;
  int         checks = 0;
  logic [7:0] sbq[$];
  int         rdy_mode = 0;
  int         bytes_seen = 0;
  logic       mon_stall = 1'b0;
  logic [7:0] mon_held = '0;

  adc_capture_stream #(
    .DATA_W       (DW),
    .DEPTH        (DEPTH),
    .PRETRIG      (PRETRIG),
    .DECIM_W      (DECIM_W)
`ifdef ADC_CAPTURE_AUTOTRIG_EN
    ,
    .AUTO_SAMPLES (AUTO_N)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .adc_data     (adc_data),
    .arm          (arm),
    .decim        (decim),
    .trig_level   (trig_level),
    .trig_falling (trig_falling),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .triggered    (triggered)
`ifdef ADC_CAPTURE_AUTOTRIG_EN
    ,
    .auto_trig    (auto_trig)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ready pattern: always, one cycle in three, or random.
  initial begin
    int k = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (k % 3 == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      k++;
    end
  end

  // Monitor: pops the scoreboard on each transfer and checks hold-while-stalled.
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_stall = 1'b0;
      end else begin
        if (mon_stall) begin
          check("hold_valid", 32'(tx_valid), 32'd1);
          check("hold_data", 32'(tx_data), 32'(mon_held));
        end
        if (tx_valid && tx_ready) begin
          bytes_seen++;
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %02h expected none", tx_data);
          end else begin
            exp = sbq.pop_front();
            check("frame_byte", 32'(tx_data), 32'(exp));
          end
        end
        mon_stall = tx_valid && !tx_ready;
        mon_held  = tx_data;
      end
    end
  end

  function automatic logic [DW-1:0] gen(input int dmode, input int rel);
    case (dmode)
      0:       return DW'(rel);
      1:       return DW'($urandom);
      2:       return (rel < 40) ? DW'(12'h100) : DW'(12'hABC);
      default: return DW'(12'h005);
    endcase
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    arm   = 1'b0;
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_triggered", 32'(triggered), 32'd0);
    sbq.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_rst_busy", 32'(busy), 32'd0);
  endtask

  // One capture: arm, feed samples through the reference model, then drain the frame.
  task automatic run_frame(input int dmode, input int unsigned dec, input logic [DW-1:0] lvl,
                           input logic fall, input int rmode, input bit arm_in_send,
                           input bit abort);
    logic [DW-1:0] kept[$];
    logic [DW-1:0] v, pv, s;
    int  rel = 0;
    int  tidx = -1;
    int  wcnt = 0;
    int  n, b0;
    bit  done = 0;
    bit  forced = 0;
    bit  trig_now;
    bit  idle_seen = 0;

    rdy_mode = rmode;
    @(posedge clk);
    #1;
    decim        = DECIM_W'(dec);
    trig_level   = lvl;
    trig_falling = fall;
    arm          = 1'b1;
    adc_data     = '0;
    @(posedge clk);
    #1;
    arm = 1'b0;
    check("busy_after_arm", 32'(busy), 32'd1);
    check("trig_clear_at_arm", 32'(triggered), 32'd0);
    // These must have been latched at arm; scramble them for the rest of the capture.
    decim        = DECIM_W'($urandom);
    trig_level   = DW'($urandom);
    trig_falling = 1'($urandom_range(0, 1));

    for (int g = 0; g < 2000 && !done; g++) begin
      v        = gen(dmode, rel);
      adc_data = v;
      arm      = ($urandom_range(0, 7) == 0);
      trig_now = 0;
      if ((rel + 1) % (int'(dec) + 1) == 0) begin
        kept.push_back(v);
        n = kept.size();
        if (tidx < 0 && n > int'(PRETRIG)) begin
          wcnt++;
          pv = kept[n-2];
          if (fall ? (pv >= lvl && v < lvl) : (pv < lvl && v >= lvl)) tidx = n - 1;
`ifdef ADC_CAPTURE_AUTOTRIG_EN
          else if (wcnt == int'(AUTO_N)) begin
            tidx   = n - 1;
            forced = 1;
          end
`endif
          trig_now = (tidx >= 0);
        end
        if (tidx >= 0 && n - 1 == tidx + int'(POST_N)) begin
          sbq.push_back(8'hA5);
`ifdef ADC_CAPTURE_AUTOTRIG_EN
          sbq.push_back(forced ? 8'h01 : 8'h00);
`endif
          for (int i = tidx - int'(PRETRIG); i <= tidx + int'(POST_N); i++) begin
            s = kept[i];
            sbq.push_back(8'(16'(s) >> 8));
            sbq.push_back(s[7:0]);
          end
          done = 1;
        end
      end
      @(posedge clk);
      #1;
      if (trig_now) begin
        check("triggered_set", 32'(triggered), 32'd1);
        check("busy_capture", 32'(busy), 32'd1);
`ifdef ADC_CAPTURE_AUTOTRIG_EN
        check("auto_trig", 32'(auto_trig), 32'(forced));
`endif
      end
      rel++;
    end

    arm = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL capture_timeout: got no trigger frame expected one within 2000 cycles");
      do_reset();
      return;
    end

    b0 = bytes_seen;
    for (int g = 0; g < 3000; g++) begin
      if (abort && bytes_seen - b0 >= 5) begin
        do_reset();
        return;
      end
      // Holding arm through the final transfer cycle must not restart a capture.
      arm      = arm_in_send && (sbq.size() > 0);
      adc_data = DW'($urandom);
      if (!busy && sbq.size() == 0) begin
        idle_seen = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    arm = 1'b0;
    if (!idle_seen) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got busy=%0d pending=%0d expected idle", busy, sbq.size());
      do_reset();
      return;
    end
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_triggered", 32'(triggered), 32'd0);
    check("idle_tx_valid", 32'(tx_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("stay_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #2;
    check("reset_tx_data", 32'(tx_data), 32'd0);
    check("reset_tx_valid", 32'(tx_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_triggered", 32'(triggered), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_frame(0, 0, DW'(20), 1'b0, 0, 1'b0, 1'b0);        // ramp, frame 16..31
    run_frame(0, 0, DW'(20), 1'b0, 1, 1'b0, 1'b0);        // same, throttled link
    run_frame(0, 3, DW'(40), 1'b0, 2, 1'b0, 1'b0);        // decimated ramp
    run_frame(2, 0, DW'(12'h800), 1'b0, 0, 1'b1, 1'b0);   // 0xABC held, arm in send
    run_frame(1, 1, DW'(12'h800), 1'b1, 0, 1'b0, 1'b1);   // abort mid-send
    run_frame(0, 0, DW'(20), 1'b0, 0, 1'b0, 1'b0);        // clean frame after reset
    for (int f = 0; f < 8; f++) begin
      run_frame(1, $urandom_range(0, 3), DW'($urandom_range(12'h400, 12'hC00)),
                1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                1'b0);
    end
`ifdef ADC_CAPTURE_AUTOTRIG_EN
    run_frame(3, 0, DW'(12'h800), 1'b0, 0, 1'b0, 1'b0);   // forced trigger
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
